// File: rtl/xup_or_pkg.sv
// Shared helpers for the pipelined OR reduction tree (xup_or_tree_pipe).
// Computes the tree depth and the lane count feeding each level, so the top
// and its per-level stages agree on every segment width.
package xup_or_pkg;

   // Widest OR node a single tree level may use.
   localparam int MAX_FANIN = 8;

   // Number of registered levels: ceil(log_f(n)), never less than one.
   function automatic int clog_fanin(input int n, input int f);
      int levels;
      int reach;
      levels = 0;
      reach  = 1;
      if (f >= 2) begin
         while (reach < n) begin
            reach  = reach * f;
            levels = levels + 1;
         end
      end
      if (levels == 0) begin
         levels = 1;
      end
      return levels;
   endfunction

   // Lanes entering level k: level 0 sees n lanes, each later level sees
   // ceil(previous / f) lanes.
   function automatic int lanes_at_level(input int n, input int f, input int k);
      int lanes;
      lanes = n;
      for (int i = 0; i < k; i++) begin
         lanes = (lanes + f - 1) / f;
      end
      return lanes;
   endfunction

   // Lane position of level k's input segment inside the flat link bus that
   // carries every level's input side by side.
   function automatic int lane_offset(input int n, input int f, input int k);
      int offset;
      offset = 0;
      for (int i = 0; i < k; i++) begin
         offset = offset + lanes_at_level(n, f, i);
      end
      return offset;
   endfunction

endpackage

// File: rtl/xup_or_stage.sv
// One registered level of the OR tree: groups of FANIN input lanes are ORed
// into one output lane and captured with a valid bit under ready/valid flow
// control. DELAY is a simulation-only gate-delay figure and has no effect here.
module xup_or_stage
   import xup_or_pkg::*;
#(
   parameter int LANES_IN  = 8,
   parameter int FANIN     = 4,
   parameter int WIDTH     = 1,
   parameter int DELAY     = 3,
   localparam int LANES_OUT = (LANES_IN + FANIN - 1) / FANIN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       up_valid,
   input  logic [LANES_IN*WIDTH-1:0]  up_data,
   output logic                       up_ready,
   output logic                       dn_valid,
   output logic [LANES_OUT*WIDTH-1:0] dn_data,
   input  logic                       dn_ready
);

   if (FANIN < 2 || FANIN > MAX_FANIN || LANES_IN < 1 || DELAY < 0) begin : g_bad_params
      $error("xup_or_stage: parameter out of range");
   end

   // The last node of the level may be short of inputs; the zero extension
   // supplies the missing lanes, which are neutral for OR.
   localparam int PAD_W = LANES_OUT * FANIN * WIDTH;

   logic [PAD_W-1:0]           padded;
   logic [LANES_OUT*WIDTH-1:0] or_data;
   logic                       v;
   logic [LANES_OUT*WIDTH-1:0] d;
   logic                       load;

   assign padded = PAD_W'(up_data);

   // OR each group of FANIN lanes into one output lane.
   always_comb begin
      // NOTE: default assignment first so no path leaves or_data unassigned (no latch).
      or_data = '0;
      for (int j = 0; j < LANES_OUT; j++) begin
         for (int i = 0; i < FANIN; i++) begin
            or_data[j*WIDTH +: WIDTH] = or_data[j*WIDTH +: WIDTH]
                                      | padded[(j*FANIN + i)*WIDTH +: WIDTH];
         end
      end
   end

   // Room exists when the level is empty or its word leaves this cycle,
   // which lets a full level that is drained reload in the same cycle.
   assign up_ready = !v | dn_ready;
   assign load     = up_valid & up_ready;

   // Level register: capture on load, empty when drained with nothing to load.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the data register is reset too, because its value is visible
         // on out_data right after reset and must read as zero.
         v <= 1'b0;
         d <= '0;
      end else if (load) begin
         // NOTE: non-blocking assignments so every level samples the values
         // from before this edge, exactly like chained flip-flops.
         v <= 1'b1;
         d <= or_data;
      end else if (dn_ready) begin
         v <= 1'b0;
      end
   end

   assign dn_valid = v;
   assign dn_data  = d;

endmodule

// File: rtl/xup_or_tree_pipe.sv
// Pipelined N_INPUTS-lane, WIDTH-bit bitwise OR reduction with ready/valid
// flow control, built from LEVELS chained xup_or_stage instances.
// Optional feature macro XUP_OR_STICKY_EN: adds port acc_clr and an
// accumulator so out_data is the OR of all words since the last clear.
module xup_or_tree_pipe
   import xup_or_pkg::*;
#(
   parameter int N_INPUTS    = 8,
   parameter int WIDTH       = 1,
   parameter int STAGE_FANIN = 4,
   parameter int DELAY       = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_INPUTS*WIDTH-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef XUP_OR_STICKY_EN
   ,
   input  logic                      acc_clr
`endif
);

   if (N_INPUTS < 1 || WIDTH < 1) begin : g_bad_params
      $error("xup_or_tree_pipe: parameter out of range");
   end

   localparam int LEVELS  = clog_fanin(N_INPUTS, STAGE_FANIN);
   localparam int LINK_W  = lane_offset(N_INPUTS, STAGE_FANIN, LEVELS + 1) * WIDTH;
   localparam int OUT_LSB = lane_offset(N_INPUTS, STAGE_FANIN, LEVELS) * WIDTH;

   // vld[k]/rdy[k] form the handshake into level k; index LEVELS is the
   // output port handshake.
   logic [LEVELS:0] vld;
   logic [LEVELS:0] rdy;
   // Segment k of link is the data entering level k; the final segment is
   // the single-lane result of the last level.
   logic [LINK_W-1:0] link;

   assign vld[0]                 = in_valid;
   assign link[0 +: N_INPUTS*WIDTH] = in_data;
   assign rdy[LEVELS]            = out_ready;
   assign in_ready               = !reset & rdy[0];
   assign out_valid              = vld[LEVELS];

   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int LANES_IN  = lanes_at_level(N_INPUTS, STAGE_FANIN, k);
      localparam int LANES_OUT = lanes_at_level(N_INPUTS, STAGE_FANIN, k + 1);
      localparam int IN_LSB    = lane_offset(N_INPUTS, STAGE_FANIN, k) * WIDTH;
      localparam int DN_LSB    = lane_offset(N_INPUTS, STAGE_FANIN, k + 1) * WIDTH;

      xup_or_stage #(
         .LANES_IN (LANES_IN),
         .FANIN    (STAGE_FANIN),
         .WIDTH    (WIDTH),
         .DELAY    (DELAY)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .up_valid (vld[k]),
         .up_data  (link[IN_LSB +: LANES_IN*WIDTH]),
         .up_ready (rdy[k]),
         .dn_valid (vld[k+1]),
         .dn_data  (link[DN_LSB +: LANES_OUT*WIDTH]),
         .dn_ready (rdy[k+1])
      );
   end

`ifdef XUP_OR_STICKY_EN
   localparam int LAST_LANES = lanes_at_level(N_INPUTS, STAGE_FANIN, LEVELS - 1);
   localparam int LAST_LSB   = lane_offset(N_INPUTS, STAGE_FANIN, LEVELS - 1) * WIDTH;

   logic [WIDTH-1:0] new_word;
   logic [WIDTH-1:0] acc;
   logic             out_load;

   // The word the output level captures this cycle: OR of its input lanes.
   always_comb begin
      new_word = '0;
      for (int i = 0; i < LAST_LANES; i++) begin
         new_word = new_word | link[LAST_LSB + i*WIDTH +: WIDTH];
      end
   end

   assign out_load = vld[LEVELS-1] & rdy[LEVELS-1];

   // Accumulator: fold each word into acc as it reaches the output level;
   // acc_clr drops history (the new word survives when both coincide).
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else if (out_load) begin
         acc <= (acc_clr ? '0 : acc) | new_word;
      end else if (acc_clr) begin
         acc <= '0;
      end
   end

   assign out_data = acc;
`else
   assign out_data = link[OUT_LSB +: WIDTH];
`endif

endmodule

// File: tb/tb_xup_or_tree_pipe.sv
// Self-checking bench for xup_or_tree_pipe. Three instances cover N=8/W=1,
// N=5/W=4 (padded lanes) and N=1/W=8 (single level). Accumulator behaviour
// is exercised when XUP_OR_STICKY_EN is defined.
module tb_xup_or_tree_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: 8 lanes x 1 bit, fan-in 4 -> 2 levels
   logic [7:0]  a_in_data;
   logic        a_in_valid, a_in_ready;
   logic [0:0]  a_out_data;
   logic        a_out_valid, a_out_ready;
   // Instance B: 5 lanes x 4 bits, fan-in 4 -> 2 levels
   logic [19:0] b_in_data;
   logic        b_in_valid, b_in_ready;
   logic [3:0]  b_out_data;
   logic        b_out_valid, b_out_ready;
   // Instance C: 1 lane x 8 bits -> 1 level
   logic [7:0]  c_in_data;
   logic        c_in_valid, c_in_ready;
   logic [7:0]  c_out_data;
   logic        c_out_valid, c_out_ready;

`ifdef XUP_OR_STICKY_EN
   logic a_acc_clr, b_acc_clr, c_acc_clr;
   logic [0:0] a_acc;
   logic [3:0] b_acc;
   logic [7:0] c_acc;
`endif

   xup_or_tree_pipe #(.N_INPUTS(8), .WIDTH(1), .STAGE_FANIN(4), .DELAY(3)) u_dut_a (
      .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready)
`ifdef XUP_OR_STICKY_EN
      , .acc_clr(a_acc_clr)
`endif
   );

   xup_or_tree_pipe #(.N_INPUTS(5), .WIDTH(4), .STAGE_FANIN(4), .DELAY(3)) u_dut_b (
      .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready)
`ifdef XUP_OR_STICKY_EN
      , .acc_clr(b_acc_clr)
`endif
   );

   xup_or_tree_pipe #(.N_INPUTS(1), .WIDTH(8), .STAGE_FANIN(4), .DELAY(3)) u_dut_c (
      .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
      .out_ready(c_out_ready)
`ifdef XUP_OR_STICKY_EN
      , .acc_clr(c_acc_clr)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the value out_data must show for an accepted word,
   // taken in acceptance order.
   function automatic logic [0:0] a_model(input logic [7:0] w);
      logic [0:0] r;
      r = |w;
`ifdef XUP_OR_STICKY_EN
      a_acc = a_acc | r;
      r     = a_acc;
`endif
      return r;
   endfunction

   function automatic logic [3:0] b_model(input logic [19:0] w);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 0; i < 5; i++) r = r | w[i*4 +: 4];
`ifdef XUP_OR_STICKY_EN
      b_acc = b_acc | r;
      r     = b_acc;
`endif
      return r;
   endfunction

   function automatic logic [7:0] c_model(input logic [7:0] w);
      logic [7:0] r;
      r = w;
`ifdef XUP_OR_STICKY_EN
      c_acc = c_acc | r;
      r     = c_acc;
`endif
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   logic [0:0] e1 [2];
   logic [7:0] w2 [4];
   logic [0:0] e2 [4];
   logic [0:0] got2 [$];
   logic [3:0] e3a, e3b;
   logic [7:0] e6;
   logic [7:0] sb [$];
   logic       stall_prev;
   logic [7:0] stall_data;
   int         idx;
`ifdef XUP_OR_STICKY_EN
   logic [19:0] w5 [3];
`endif

   initial begin
      reset = 1'b1;
      a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
`ifdef XUP_OR_STICKY_EN
      a_acc_clr = 1'b0; b_acc_clr = 1'b0; c_acc_clr = 1'b0;
      a_acc = '0; b_acc = '0; c_acc = '0;
`endif
      stall_prev = 1'b0;
      stall_data = '0;

      // Reset: in_ready low while reset is high, then idle state.
      @(negedge clk);
      check("rst_in_ready_a", 64'(a_in_ready), 64'(0));
      check("rst_in_ready_b", 64'(b_in_ready), 64'(0));
      check("rst_in_ready_c", 64'(c_in_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid_a", 64'(a_out_valid), 64'(0));
      check("rst_out_data_a",  64'(a_out_data),  64'(0));
      check("rst_after_in_ready_a", 64'(a_in_ready), 64'(1));
      check("rst_out_valid_b", 64'(b_out_valid), 64'(0));
      check("rst_out_data_b",  64'(b_out_data),  64'(0));
      check("rst_out_valid_c", 64'(c_out_valid), 64'(0));
      check("rst_out_data_c",  64'(c_out_data),  64'(0));
      next_cycle();

      // Test 1: two back-to-back words, 2-cycle latency, valid for 2 cycles.
      a_out_ready = 1'b1;
      e1[0] = a_model(8'h00);
      e1[1] = a_model(8'h10);
      for (int cyc = 0; cyc < 6; cyc++) begin
         a_in_valid = (cyc < 2);
         a_in_data  = (cyc == 1) ? 8'h10 : 8'h00;
         @(negedge clk);
         if (cyc < 2) check("t1_in_ready", 64'(a_in_ready), 64'(1));
         check("t1_out_valid", 64'(a_out_valid), 64'(cyc == 2 || cyc == 3));
         if (cyc == 2) check("t1_out_data0", 64'(a_out_data), 64'(e1[0]));
         if (cyc == 3) check("t1_out_data1", 64'(a_out_data), 64'(e1[1]));
         next_cycle();
      end

      // Test 2: consumer stalled, pipeline fills at 2 words, then drains in order.
      w2[0] = 8'h01; w2[1] = 8'h00; w2[2] = 8'h80; w2[3] = 8'h00;
      for (int i = 0; i < 4; i++) e2[i] = a_model(w2[i]);
      a_out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         a_in_valid = 1'b1;
         a_in_data  = w2[idx];
         @(negedge clk);
         check("t2_in_ready", 64'(a_in_ready), 64'(cyc < 2));
         if (cyc >= 2) begin
            check("t2_stall_valid", 64'(a_out_valid), 64'(1));
            check("t2_stall_data",  64'(a_out_data),  64'(e2[0]));
         end
         if (cyc < 2) idx++;
         next_cycle();
      end
      a_out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got2.size() < 4; cyc++) begin
         a_in_valid = (idx < 4);
         a_in_data  = w2[(idx < 4) ? idx : 0];
         @(negedge clk);
         if (a_out_valid && a_out_ready) got2.push_back(a_out_data);
         if (a_in_valid && a_in_ready) idx++;
         next_cycle();
      end
      a_in_valid = 1'b0;
      check("t2_count", 64'(got2.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         check("t2_word", 64'((i < got2.size()) ? got2[i] : 1'bx), 64'(e2[i]));
      @(negedge clk);
      check("t2_idle", 64'(a_out_valid), 64'(0));
      next_cycle();

      // Test 3: 5 lanes of 4 bits; the lone lane in the short node is padded with zeros.
      b_out_ready = 1'b1;
      e3a = b_model(20'h08421);
      e3b = b_model(20'h60000);
      for (int cyc = 0; cyc < 5; cyc++) begin
         b_in_valid = (cyc < 2);
         b_in_data  = (cyc == 0) ? 20'h08421 : 20'h60000;
         @(negedge clk);
         check("t3_out_valid", 64'(b_out_valid), 64'(cyc == 2 || cyc == 3));
         if (cyc == 2) begin
            check("t3_all_lanes", 64'(b_out_data), 64'(e3a));
            check("t3_full_f",    64'(b_out_data), 64'(4'hF));
         end
         if (cyc == 3) check("t3_pad_lane", 64'(b_out_data), 64'(e3b));
         next_cycle();
      end

      // Test 4: reset with two words in flight discards both.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'h10;
      @(negedge clk);
      check("t4_accept0", 64'(a_in_ready), 64'(1));
      next_cycle();
      a_in_data = 8'h01;
      @(negedge clk);
      check("t4_accept1", 64'(a_in_ready), 64'(1));
      next_cycle();
      a_in_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      check("t4_rst_in_ready", 64'(a_in_ready), 64'(0));
      check("t4_full_before",  64'(a_out_valid), 64'(1));
      next_cycle();
      reset = 1'b0;
`ifdef XUP_OR_STICKY_EN
      a_acc = '0; b_acc = '0; c_acc = '0;
`endif
      @(negedge clk);
      check("t4_out_valid", 64'(a_out_valid), 64'(0));
      check("t4_out_data",  64'(a_out_data),  64'(0));
      check("t4_in_ready",  64'(a_in_ready),  64'(1));
      next_cycle();
      a_out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         check("t4_no_stale", 64'(a_out_valid), 64'(0));
         next_cycle();
      end

`ifdef XUP_OR_STICKY_EN
      // Test 5: accumulator 1, 3, then 8 with acc_clr on the third output load;
      // acc_clr alone later zeroes out_data without touching out_valid.
      w5[0] = 20'h00001; w5[1] = 20'h00200; w5[2] = 20'h80000;
      b_out_ready = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         b_in_valid = (cyc < 3);
         b_in_data  = w5[(cyc < 3) ? cyc : 0];
         b_acc_clr  = (cyc == 3 || cyc == 5);
         @(negedge clk);
         check("t5_out_valid", 64'(b_out_valid), 64'(cyc >= 2 && cyc <= 4));
         if (cyc == 2) check("t5_acc1", 64'(b_out_data), 64'(4'h1));
         if (cyc == 3) check("t5_acc3", 64'(b_out_data), 64'(4'h3));
         if (cyc == 4) check("t5_clr_load", 64'(b_out_data), 64'(4'h8));
         if (cyc == 6) check("t5_clr_only", 64'(b_out_data), 64'(4'h0));
         next_cycle();
      end
      b_acc_clr  = 1'b0;
      b_in_valid = 1'b0;
      b_acc      = '0;
`endif

      // Test 6: single-lane, single-level instance.
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      c_in_data   = 8'hA5;
      e6 = c_model(8'hA5);
      @(negedge clk);
      check("t6_in_ready", 64'(c_in_ready), 64'(1));
      check("t6_not_yet",  64'(c_out_valid), 64'(0));
      next_cycle();
      c_in_valid = 1'b0;
      @(negedge clk);
      check("t6_valid", 64'(c_out_valid), 64'(1));
      check("t6_data",  64'(c_out_data),  64'(e6));
      check("t6_a5",    64'(c_out_data),  64'(8'hA5));
      next_cycle();

      // Random valid/ready stress against a scoreboard of accepted words.
      for (int cyc = 0; cyc < 800; cyc++) begin
         c_in_valid  = ($urandom_range(0, 3) != 0);
         c_in_data   = 8'($urandom);
         c_out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (stall_prev) begin
            check("t6_hold_valid", 64'(c_out_valid), 64'(1));
            check("t6_hold_data",  64'(c_out_data),  64'(stall_data));
         end
         if (sb.size() == 0) check("t6_empty_ready", 64'(c_in_ready), 64'(1));
         if (c_out_valid && c_out_ready) begin
            check("t6_has_word", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) check("t6_word", 64'(c_out_data), 64'(sb.pop_front()));
         end
         stall_prev = c_out_valid && !c_out_ready;
         stall_data = c_out_data;
         if (c_in_valid && c_in_ready) sb.push_back(c_model(c_in_data));
         check("t6_occupancy", 64'(sb.size() <= 1), 64'(1));
         next_cycle();
      end
      c_in_valid  = 1'b0;
      c_out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && sb.size() != 0; cyc++) begin
         @(negedge clk);
         if (c_out_valid && sb.size() != 0) check("t6_drain_word", 64'(c_out_data), 64'(sb.pop_front()));
         next_cycle();
      end
      check("t6_drained", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
